// File: rtl/alu_exec_seq.sv
// alu_exec_seq: execute-stage sequencer for the 8-bit PB-V datapath.
//   Accepts one ALU op per in_valid/in_ready handshake. ADD/SUB/MUL/compare
//   complete in one cycle; DIV/MOD run on an internal restoring divider.
//   The result is held on out_valid/out_ready until writeback consumes it.
// Ports:
//   clk, clrn (async active-low)  clock and reset (also resets the divider)
//   in_valid, in_ready, op, a, b  operation input handshake
//   out_valid, out_ready          result output handshake
//   result, rem, flag, err        result payload
//   busy                          divider sequence in progress

// div_restoring: 32/16 restoring divider, one quotient bit per cycle.
//   start loads operands and clears ready; 32 iterations follow, then
//   ready rises and q/r hold until the next start. Only the low OW bits
//   of quotient and remainder are exported.
module div_restoring #(
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          start,
    input  logic [31:0]   a,
    input  logic [15:0]   b,
    output logic [OW-1:0] q,
    output logic [OW-1:0] r,
    output logic          ready
);
    logic [31:0] qr;
    logic [15:0] rr, bd;
    logic [4:0]  cnt;
    logic        act;
    logic [16:0] sh, tr;

    // Shift the next dividend bit into the partial remainder and trial-subtract;
    // a borrow (tr[16]) means restore, i.e. keep the shifted value.
    assign sh = {rr, qr[31]};
    assign tr = sh - {1'b0, bd};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            qr    <= '0;
            rr    <= '0;
            bd    <= '0;
            cnt   <= '0;
            act   <= 1'b0;
            ready <= 1'b0;
        end else if (start) begin
            qr    <= a;
            rr    <= '0;
            bd    <= b;
            cnt   <= '0;
            act   <= 1'b1;
            ready <= 1'b0;
        end else if (act) begin
            qr  <= {qr[30:0], ~tr[16]};
            rr  <= tr[16] ? sh[15:0] : tr[15:0];
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                act   <= 1'b0;
                ready <= 1'b1;
            end
        end
    end

    assign q = qr[OW-1:0];
    assign r = rr[OW-1:0];
endmodule

module alu_exec_seq #(
    parameter int WDOG = 40
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic [7:0] rem,
    output logic       flag,
    output logic       err,
    output logic       busy
);
    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_MUL = 6'd2;
    localparam logic [5:0] OP_DIV = 6'd3;
    localparam logic [5:0] OP_LT  = 6'd4;
    localparam logic [5:0] OP_EQ  = 6'd5;
    localparam logic [5:0] OP_GT  = 6'd6;
    localparam logic [5:0] OP_MOD = 6'd7;
    localparam logic [5:0] WD     = 6'(WDOG);

    typedef enum logic [1:0] {IDLE, DIV_START, DIV_WAIT, HOLD} state_t;

    state_t     state;
    logic [5:0] op_r;
    logic [7:0] a_r, b_r;
    logic [5:0] wd;
    logic [7:0] dif, c_res, c_rem, div_q, div_r;
    logic       c_flag, c_err, is_div, div_start, div_ready;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state == DIV_START) || (state == DIV_WAIT);
    assign div_start = (state == DIV_START);
    assign dif       = a - b;
    assign is_div    = ((op == OP_DIV) || (op == OP_MOD)) && (b != 8'd0);

    // Single-cycle result, also covering divide-by-zero; only used when the
    // op is not a real divide.
    always_comb begin
        c_res  = '0;
        c_rem  = '0;
        c_flag = 1'b0;
        c_err  = 1'b0;
        case (op)
            OP_ADD: c_res = a + b;
            OP_SUB: c_res = dif;
            OP_MUL: c_res = a * b;
            OP_DIV: begin
                c_res  = 8'hFF;
                c_rem  = a;
                c_flag = 1'b1;
            end
            OP_MOD: begin
                c_res  = a;
                c_rem  = a;
                c_flag = 1'b1;
            end
            // Compares ignore subtraction overflow, matching existing semantics.
            OP_LT: begin
                c_flag = dif[7];
                c_res  = {7'b0, dif[7]};
            end
            OP_EQ: begin
                c_flag = (a == b);
                c_res  = {7'b0, a == b};
            end
            OP_GT: begin
                c_flag = (dif != 8'd0) && !dif[7];
                c_res  = {7'b0, (dif != 8'd0) && !dif[7]};
            end
            default: c_err = 1'b1;
        endcase
    end

    div_restoring #(.OW(8)) u_div (
        .clk   (clk),
        .clrn  (clrn),
        .start (div_start),
        .a     ({24'b0, a_r}),
        .b     ({8'b0, b_r}),
        .q     (div_q),
        .r     (div_r),
        .ready (div_ready)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            wd     <= '0;
            result <= '0;
            rem    <= '0;
            flag   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r <= op;
                    a_r  <= a;
                    b_r  <= b;
                    if (is_div) begin
                        state <= DIV_START;
                    end else begin
                        state  <= HOLD;
                        result <= c_res;
                        rem    <= c_rem;
                        flag   <= c_flag;
                        err    <= c_err;
                    end
                end
                DIV_START: begin
                    state <= DIV_WAIT;
                    wd    <= '0;
                end
                // ready is only trusted here: start has already cleared any
                // stale ready left over from a previous divide.
                DIV_WAIT: if (div_ready) begin
                    state  <= HOLD;
                    result <= (op_r == OP_MOD) ? div_r : div_q;
                    rem    <= div_r;
                    flag   <= 1'b0;
                    err    <= 1'b0;
                end else if (wd == WD) begin
                    state  <= HOLD;
                    result <= '0;
                    rem    <= '0;
                    flag   <= 1'b0;
                    err    <= 1'b1;
                end else begin
                    wd <= wd + 6'd1;
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
